// File: rtl/pkt_recv.sv
`default_nettype none
// ============================================================================
//  Module      : pkt_recv
//  Description : NoC local-port packet receiver. Buffers incoming flits,
//                strips the header, reads the payload size and packs
//                payload flit pairs into memory words written to a
//                CPU-armed destination buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
module pkt_recv #(
    parameter int MEMORY_BUS_WIDTH = 32,
    parameter int FLIT_WIDTH       = 16,
    parameter int FIFO_DEPTH       = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        rx,
    input  logic [FLIT_WIDTH-1:0]       data_i,
    output logic                        credit_o,
    input  logic                        start,
    input  logic [MEMORY_BUS_WIDTH-1:0] base_addr,
    input  logic [15:0]                 max_words,
    output logic [MEMORY_BUS_WIDTH-1:0] mem_addr,
    output logic [MEMORY_BUS_WIDTH-1:0] mem_data,
    output logic                        mem_we,
    input  logic                        mem_grant,
    output logic                        busy,
    output logic                        done,
    output logic [15:0]                 recv_size,
    output logic                        overflow
);

    localparam int c_AW = $clog2(FIFO_DEPTH);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_HEADER  = 3'd1;
    localparam logic [2:0] c_SIZE    = 3'd2;
    localparam logic [2:0] c_PAYLOAD = 3'd3;
    localparam logic [2:0] c_FLUSH   = 3'd4;
    localparam logic [2:0] c_DONE    = 3'd5;

    logic [2:0]                  r_state;
    logic [2:0]                  w_state_nxt;

    logic [FLIT_WIDTH-1:0]       r_fifo [FIFO_DEPTH];
    logic [c_AW:0]               r_wr_ptr;
    logic [c_AW:0]               r_rd_ptr;
    logic                        w_empty;
    logic                        w_full;
    logic                        w_push;
    logic                        w_pop;
    logic [FLIT_WIDTH-1:0]       w_fifo_rd;

    logic [MEMORY_BUS_WIDTH-1:0] r_base;
    logic [15:0]                 r_max_words;
    logic [15:0]                 r_word_cnt;
    logic [15:0]                 r_flit_cnt;
    logic [15:0]                 r_size;
    logic [FLIT_WIDTH-1:0]       r_low;
    logic                        r_overflow;
    logic                        r_mem_we;
    logic [MEMORY_BUS_WIDTH-1:0] r_mem_addr;
    logic [MEMORY_BUS_WIDTH-1:0] r_mem_data;

    logic                        w_pending;
    logic                        w_last;
    logic                        w_issue;
    logic [MEMORY_BUS_WIDTH-1:0] w_word;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                       (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign w_fifo_rd = r_fifo[r_rd_ptr[c_AW-1:0]];

    assign busy      = (r_state != c_IDLE);
    assign done      = (r_state == c_DONE);
    assign credit_o  = busy && !w_full;
    assign w_push    = rx && credit_o;

    // A word still waiting for acceptance blocks further payload pops.
    assign w_pending = r_mem_we && !mem_grant;
    assign w_last    = ((r_flit_cnt + 16'd1) == r_size);

    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_data  = r_mem_data;
    assign recv_size = r_size;
    assign overflow  = r_overflow;

    // FIFO storage; contents need no reset since the pointers define validity.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_fifo[r_wr_ptr[c_AW-1:0]] <= data_i;
        end
    end

    // FIFO pointers; push and pop in the same cycle leave occupancy unchanged.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) r_state <= c_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next state, FIFO pop and word-issue decisions.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_issue     = 1'b0;
        w_word      = '0;
        case (r_state)
            c_IDLE: begin
                if (start) w_state_nxt = c_HEADER;
            end
            c_HEADER: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = c_SIZE;
                end
            end
            c_SIZE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = (w_fifo_rd == '0) ? c_DONE : c_PAYLOAD;
                end
            end
            c_PAYLOAD: begin
                if (r_flit_cnt == r_size) begin
                    // All flits consumed; finish once the last word is taken.
                    if (!w_pending) w_state_nxt = c_DONE;
                end else if (!w_empty && !w_pending) begin
                    w_pop = 1'b1;
                    if (r_flit_cnt[0]) begin
                        w_issue = 1'b1;
                        w_word  = {w_fifo_rd, r_low};
                    end else if (w_last) begin
                        w_issue     = 1'b1;
                        w_word      = {{FLIT_WIDTH{1'b0}}, w_fifo_rd};
                        w_state_nxt = c_FLUSH;
                    end
                end
            end
            c_FLUSH: begin
                if (!w_pending) w_state_nxt = c_DONE;
            end
            c_DONE: begin
                w_state_nxt = c_IDLE;
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // Packet bookkeeping and the single-outstanding memory write port.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_base      <= '0;
            r_max_words <= '0;
            r_word_cnt  <= '0;
            r_flit_cnt  <= '0;
            r_size      <= '0;
            r_low       <= '0;
            r_overflow  <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_data  <= '0;
        end else begin
            if (r_mem_we && mem_grant) r_mem_we <= 1'b0;

            if (r_state == c_IDLE && start) begin
                r_base      <= base_addr;
                r_max_words <= max_words;
                r_word_cnt  <= '0;
                r_flit_cnt  <= '0;
                r_overflow  <= 1'b0;
            end

            if (r_state == c_SIZE && w_pop) r_size <= 16'(w_fifo_rd);

            if (r_state == c_PAYLOAD && w_pop) begin
                r_flit_cnt <= r_flit_cnt + 16'd1;
                if (!r_flit_cnt[0]) r_low <= w_fifo_rd;
            end

            // Words past the buffer capacity are dropped but still counted.
            if (w_issue) begin
                if (r_word_cnt < r_max_words) begin
                    r_mem_we   <= 1'b1;
                    r_mem_addr <= r_base + MEMORY_BUS_WIDTH'(r_word_cnt);
                    r_mem_data <= w_word;
                end else begin
                    r_overflow <= 1'b1;
                end
                r_word_cnt <= r_word_cnt + 16'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pkt_recv.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pkt_recv
//  Description : Directed self-checking bench for pkt_recv.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pkt_recv;

    logic        clock = 1'b0;
    logic        reset;
    logic        rx;
    logic [15:0] data_i;
    logic        credit_o;
    logic        start;
    logic [31:0] base_addr;
    logic [15:0] max_words;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        mem_we;
    logic        mem_grant;
    logic        busy;
    logic        done;
    logic [15:0] recv_size;
    logic        overflow;

    int          n_tests = 0;
    int          n_fail  = 0;

    logic [15:0] pkt [0:15];
    int          pkt_len  = 0;
    int          pkt_base = 0;

    int          tx_total       = 0;
    int          edge_cnt       = 0;
    int          last_push_edge = 0;
    int          wr_total       = 0;
    logic [31:0] wr_addr [0:63];
    logic [31:0] wr_data [0:63];
    logic [31:0] t5_exp  [0:3];

    always #5 clock = ~clock;

    pkt_recv #(
        .MEMORY_BUS_WIDTH (32),
        .FLIT_WIDTH       (16),
        .FIFO_DEPTH       (4)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .rx        (rx),
        .data_i    (data_i),
        .credit_o  (credit_o),
        .start     (start),
        .base_addr (base_addr),
        .max_words (max_words),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_we    (mem_we),
        .mem_grant (mem_grant),
        .busy      (busy),
        .done      (done),
        .recv_size (recv_size),
        .overflow  (overflow)
    );

    // Observe flit transfers and accepted memory writes at the active edge.
    always @(posedge clock) begin
        edge_cnt <= edge_cnt + 1;
        if (rx && credit_o) begin
            tx_total       <= tx_total + 1;
            last_push_edge <= edge_cnt;
        end
        if (mem_we && mem_grant && wr_total < 64) begin
            wr_addr[wr_total] <= mem_addr;
            wr_data[wr_total] <= mem_data;
            wr_total          <= wr_total + 1;
        end
    end

    // Flit source: presents the next untransferred flit of the loaded packet.
    initial begin
        int idx;
        rx     = 1'b0;
        data_i = '0;
        forever begin
            @(posedge clock);
            #1;
            idx    = tx_total - pkt_base;
            rx     = (idx < pkt_len);
            data_i = (idx < pkt_len) ? pkt[idx] : 16'h0000;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic do_start(input logic [31:0] base, input logic [15:0] maxw);
        base_addr = base;
        max_words = maxw;
        start     = 1'b1;
        @(negedge clock);
        start     = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int  c;
        bit  seen;
        c    = 0;
        seen = 1'b0;
        while (!seen && c < budget) begin
            @(negedge clock);
            if (done) seen = 1'b1;
            c++;
        end
        check({tag, "_done"}, 32'(seen), 32'd1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_credit"},   32'(credit_o),  32'd0);
        check({tag, "_we"},       32'(mem_we),    32'd0);
        check({tag, "_addr"},     mem_addr,       32'd0);
        check({tag, "_data"},     mem_data,       32'd0);
        check({tag, "_busy"},     32'(busy),      32'd0);
        check({tag, "_donebit"},  32'(done),      32'd0);
        check({tag, "_size"},     32'(recv_size), 32'd0);
        check({tag, "_overflow"}, 32'(overflow),  32'd0);
    endtask

    task automatic check_pulse_end(input string tag);
        @(negedge clock);
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_idle"},       32'(busy), 32'd0);
    endtask

    initial begin
        int  w0;
        int  c;
        bit  seen;
        bit  stable;

        reset     = 1'b1;
        start     = 1'b0;
        mem_grant = 1'b1;
        base_addr = '0;
        max_words = '0;
        t5_exp    = '{32'h00A100A0, 32'h00A300A2, 32'h00A500A4, 32'h00A700A6};

        repeat (3) @(negedge clock);
        check_idle_outputs("rst");
        reset = 1'b0;
        @(negedge clock);

        // Two full words, continuous stream, grant tied high.
        pkt = '{0:16'h0011, 1:16'h0004, 2:16'hAAAA, 3:16'hBBBB, 4:16'hCCCC,
                5:16'hDDDD, default:16'h0000};
        pkt_len = 6; pkt_base = tx_total; w0 = wr_total;
        do_start(32'h100, 16'd8);
        wait_done("t1", 50);
        check("t1_latency", 32'(edge_cnt - last_push_edge), 32'd3);
        check("t1_nwr",     32'(wr_total - w0), 32'd2);
        check("t1_addr0",   wr_addr[w0],     32'h00000100);
        check("t1_data0",   wr_data[w0],     32'hBBBBAAAA);
        check("t1_addr1",   wr_addr[w0 + 1], 32'h00000101);
        check("t1_data1",   wr_data[w0 + 1], 32'hDDDDCCCC);
        check("t1_size",    32'(recv_size),  32'd4);
        check("t1_ovf",     32'(overflow),   32'd0);
        check_pulse_end("t1");

        // Odd payload count: last word goes out with a zero upper half.
        pkt = '{0:16'h0022, 1:16'h0003, 2:16'h0001, 3:16'h0002, 4:16'h0003,
                default:16'h0000};
        pkt_len = 5; pkt_base = tx_total; w0 = wr_total;
        do_start(32'h200, 16'd8);
        wait_done("t2", 50);
        check("t2_nwr",   32'(wr_total - w0), 32'd2);
        check("t2_addr0", wr_addr[w0],     32'h00000200);
        check("t2_data0", wr_data[w0],     32'h00020001);
        check("t2_addr1", wr_addr[w0 + 1], 32'h00000201);
        check("t2_data1", wr_data[w0 + 1], 32'h00000003);
        check("t2_size",  32'(recv_size),  32'd3);
        check_pulse_end("t2");

        // Empty payload: no writes, done the cycle after the size flit pops.
        pkt = '{0:16'h0033, 1:16'h0000, default:16'h0000};
        pkt_len = 2; pkt_base = tx_total; w0 = wr_total;
        do_start(32'h280, 16'd8);
        wait_done("t3", 50);
        check("t3_latency", 32'(edge_cnt - last_push_edge), 32'd2);
        check("t3_nwr",     32'(wr_total - w0), 32'd0);
        check("t3_size",    32'(recv_size),  32'd0);
        check_pulse_end("t3");

        // Buffer of one word receiving two words of payload.
        pkt = '{0:16'h0044, 1:16'h0004, 2:16'h0001, 3:16'h0002, 4:16'h0003,
                5:16'h0004, default:16'h0000};
        pkt_len = 6; pkt_base = tx_total; w0 = wr_total;
        do_start(32'h300, 16'd1);
        wait_done("t4", 50);
        check("t4_nwr",      32'(wr_total - w0), 32'd1);
        check("t4_addr0",    wr_addr[w0],     32'h00000300);
        check("t4_data0",    wr_data[w0],     32'h00020001);
        check("t4_ovf",      32'(overflow),   32'd1);
        check("t4_consumed", 32'(tx_total - pkt_base), 32'd6);
        check_pulse_end("t4");

        // Memory back-pressure: FIFO fills, write held stable, then resumes.
        mem_grant = 1'b0;
        pkt = '{0:16'h0055, 1:16'h0008, 2:16'h00A0, 3:16'h00A1, 4:16'h00A2,
                5:16'h00A3, 6:16'h00A4, 7:16'h00A5, 8:16'h00A6, 9:16'h00A7,
                default:16'h0000};
        pkt_len = 10; pkt_base = tx_total; w0 = wr_total;
        do_start(32'h400, 16'd8);
        check("t5_ovf_cleared", 32'(overflow), 32'd0);
        c = 0; seen = 1'b0;
        while (!seen && c < 30) begin
            @(negedge clock);
            if (mem_we) seen = 1'b1;
            c++;
        end
        check("t5_we_rise", 32'(seen), 32'd1);
        stable = 1'b1;
        repeat (10) begin
            @(negedge clock);
            if (!(mem_we === 1'b1 && mem_addr === 32'h400 && mem_data === 32'h00A100A0))
                stable = 1'b0;
        end
        check("t5_stable",  32'(stable),   32'd1);
        check("t5_credit",  32'(credit_o), 32'd0);
        check("t5_pushed",  32'(tx_total - pkt_base), 32'd8);
        check("t5_nwr_hold", 32'(wr_total - w0), 32'd0);
        mem_grant = 1'b1;
        wait_done("t5", 60);
        check("t5_nwr", 32'(wr_total - w0), 32'd4);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("t5_addr%0d", k), wr_addr[w0 + k], 32'h400 + 32'(k));
            check($sformatf("t5_data%0d", k), wr_data[w0 + k], t5_exp[k]);
        end
        check("t5_size",     32'(recv_size), 32'd8);
        check("t5_consumed", 32'(tx_total - pkt_base), 32'd10);
        check_pulse_end("t5");

        // Reset in the middle of a packet.
        pkt = '{0:16'h0066, 1:16'h0004, 2:16'h1111, 3:16'h2222, 4:16'h3333,
                5:16'h4444, default:16'h0000};
        pkt_len = 6; pkt_base = tx_total;
        do_start(32'h500, 16'd8);
        c = 0; seen = 1'b0;
        while (!seen && c < 30) begin
            @(negedge clock);
            if (tx_total - pkt_base >= 4) seen = 1'b1;
            c++;
        end
        check("t6_two_payload", 32'(seen), 32'd1);
        reset = 1'b1;
        @(negedge clock);
        check_idle_outputs("t6_rst");
        reset = 1'b0;
        w0 = wr_total;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            check($sformatf("t6_nocredit%0d", k), 32'(credit_o), 32'd0);
        end
        check("t6_busy",     32'(busy), 32'd0);
        check("t6_no_write", 32'(wr_total - w0), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pkt_recv.md
PKT_RECV -- requirements
Module: pkt_recv

Interface
REQ-001 SHALL have parameter MEMORY_BUS_WIDTH, default 32, memory word width; SHALL equal 2*FLIT_WIDTH.
REQ-002 SHALL have parameter FLIT_WIDTH, default 16, NoC flit width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, input flit buffer entries (power of two, >=2).
REQ-004 SHALL have port clock  in  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port rx  in  1  router local-port flit valid.
REQ-007 SHALL have port data_i  in  FLIT_WIDTH  router local-port flit.
REQ-008 SHALL have port credit_o  out  1  buffer space available; a flit transfers when rx && credit_o.
REQ-009 SHALL have port start  in  1  one-cycle CPU arm pulse.
REQ-010 SHALL have port base_addr  in  MEMORY_BUS_WIDTH  destination word address, sampled on start.
REQ-011 SHALL have port max_words  in  16  destination buffer capacity in words, sampled on start.
REQ-012 SHALL have port mem_addr  out  MEMORY_BUS_WIDTH  write address.
REQ-013 SHALL have port mem_data  out  MEMORY_BUS_WIDTH  write data.
REQ-014 SHALL have port mem_we  out  1  write request; held stable until mem_grant.
REQ-015 SHALL have port mem_grant  in  1  write accepted this cycle when mem_we && mem_grant.
REQ-016 SHALL have port busy  out  1  armed or receiving.
REQ-017 SHALL have port done  out  1  one-cycle pulse at packet completion.
REQ-018 SHALL have port recv_size  out  16  payload flit count from size flit, valid from done until next start.
REQ-019 SHALL have port overflow  out  1  sticky: packet exceeded max_words; cleared on start.

Function
REQ-020 Packet format SHALL be: flit 0 header (discarded), flit 1 payload size N (unsigned), then N payload flits.
REQ-021 Flits SHALL enter a FIFO_DEPTH FIFO; credit_o SHALL be 1 iff busy and FIFO not full (credit_o=0 in IDLE).
REQ-022 FSM states SHALL be IDLE, HEADER, SIZE, PAYLOAD, FLUSH, DONE.
REQ-023 IDLE->HEADER on start; base_addr, max_words latched, word counter and overflow cleared; start ignored in other states.
REQ-024 HEADER->SIZE when one flit popped from FIFO; SIZE->PAYLOAD on pop with N>0, SIZE->DONE on pop with N=0; N latched into recv_size.
REQ-025 PAYLOAD SHALL pack flits little-end first: even-index flit into bits [FLIT_WIDTH-1:0], odd-index into upper half; a word is issued after each odd-index flit.
REQ-026 When last payload flit has even index (N odd), FSM SHALL enter FLUSH and issue the word with upper half zero; otherwise PAYLOAD->DONE after last word accepted.
REQ-027 Word k SHALL be written to base_addr+k; address arithmetic wraps modulo 2^MEMORY_BUS_WIDTH.
REQ-028 FIFO pop in PAYLOAD SHALL stall while a word is pending (mem_we && !mem_grant); at most one word outstanding.
REQ-029 Words with k >= max_words SHALL NOT be written (mem_we stays 0); flits still consumed, overflow set at first such word.
REQ-030 DONE SHALL assert done for one cycle, then return to IDLE; busy=0 in IDLE, 1 otherwise.
REQ-031 Simultaneous FIFO push and pop SHALL keep occupancy unchanged, including when full.
REQ-032 Minimum latency: last payload flit pushed at cycle t with mem_grant tied 1 -> done at t+3.

Reset
REQ-033 On reset SHALL: FSM IDLE, FIFO empty, credit_o=0, mem_we=0, mem_addr=0, mem_data=0, busy=0, done=0, recv_size=0, overflow=0.
REQ-034 Reset mid-packet SHALL abort with no further mem_we; remaining flits of that packet are not credited until next start.

Verification
REQ-035 start, base_addr=0x100, max_words=8; flits {0x0011,0x0004,0xAAAA,0xBBBB,0xCCCC,0xDDDD}, grant=1 -> writes 0x100=0xBBBBAAAA, 0x101=0xDDDDCCCC; done; recv_size=4.
REQ-036 N=3 payload {1,2,3} -> writes 0x00020001, 0x00000003 (FLUSH); done.
REQ-037 N=0 -> no mem_we, done one cycle after size flit pops, recv_size=0.
REQ-038 max_words=1, N=4 -> one write only, overflow=1, done asserted, all 6 flits consumed.
REQ-039 mem_grant held 0 for 10 cycles with rx continuous -> FIFO fills, credit_o=0, mem_addr/mem_data stable; resumes with no loss.
REQ-040 reset asserted after 2 payload flits -> all outputs at REQ-033 values next cycle; credit_o stays 0 until start.
